// File: rtl/seq_pkg.sv
// Shared sizing helpers for the programmable sequence detector.
// Widths are derived from MAX_LEN by each instantiating module.
package seq_pkg;

  function automatic int idx_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_sym_cmp.sv
// Masked symbol compare: a cleared mask bit makes that bit a wildcard.
module seq_sym_cmp #(
  parameter int SYM_W = 2
) (
  input  logic [SYM_W-1:0] sym,
  input  logic [SYM_W-1:0] pat,
  input  logic [SYM_W-1:0] mask,
  output logic             hit
);

  assign hit = ((sym ^ pat) & mask) == '0;

endmodule

// File: rtl/seq_detect_prog.sv
// Run-time programmable sequence detector with per-bit wildcards,
// selectable overlap, Mealy match pulse, registered copy and saturating count.
module seq_detect_prog
  import seq_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        cfg_we,
  input  logic [idx_w(MAX_LEN)-1:0]   cfg_idx,
  input  logic [SYM_W-1:0]            cfg_sym,
  input  logic [SYM_W-1:0]            cfg_mask,
  input  logic                        ctl_we,
  input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
  input  logic                        cfg_overlap,
  input  logic                        in_valid,
  input  logic [SYM_W-1:0]            in,
  input  logic                        cnt_clr,
  output logic                        out,
  output logic                        out_q,
  output logic [CNT_W-1:0]            match_cnt
);

  localparam int LEN_W = len_w(MAX_LEN);

  logic [MAX_LEN-1:0][SYM_W-1:0] pat, msk;
  logic [LEN_W-1:0]              len;
  logic                          overlap;
  logic [MAX_LEN-1:0]            act, nact, hit, len_en;
  logic                          fin, cfg_cyc;

  for (genvar k = 0; k < MAX_LEN; k++) begin : g_cmp
    seq_sym_cmp #(.SYM_W(SYM_W)) u_cmp (
      .sym  (in),
      .pat  (pat[k]),
      .mask (msk[k]),
      .hit  (hit[k])
    );
  end

  // Stage k extends a partial match of length k; stage 0 always starts fresh.
  always_comb begin
    len_en = '0;
    fin    = 1'b0;
    for (int k = 0; k < MAX_LEN; k++)
      len_en[k] = (k < int'(len));
    nact = hit & {act[MAX_LEN-2:0], 1'b1} & len_en;
    for (int k = 0; k < MAX_LEN; k++)
      if (int'(len) == k + 1) fin = nact[k];
  end

  assign cfg_cyc = cfg_we | ctl_we;
  assign out     = in_valid & (len != '0) & fin & ~cfg_cyc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pat       <= '0;
      msk       <= '1;
      len       <= '0;
      overlap   <= 1'b0;
      act       <= '0;
      out_q     <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (cfg_we) begin
        pat[cfg_idx] <= cfg_sym;
        msk[cfg_idx] <= cfg_mask;
      end
      if (ctl_we) begin
        len     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
        overlap <= cfg_overlap;
      end
      // Config writes discard progress; a non-overlapped match restarts cleanly.
      if (cfg_cyc || (out && !overlap)) act <= '0;
      else if (in_valid)                act <= nact;
      out_q <= out;
      if (cnt_clr)                       match_cnt <= '0;
      else if (out && match_cnt != '1)   match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule
